// File: rtl/mux3_rr_select.sv
// Select generator for a 3:1 mux: round-robin arbitration of three valid/ready
// sources with bounded bursts, holding the mux selects stable for a whole grant.
module mux3_rr_select #(
    parameter int MAX_BURST = 4,
    parameter int CW        = 4
) (
    input  logic          CK,
    input  logic          RST,
    input  logic [2:0]    REQ,
    output logic [2:0]    ACK,
    input  logic          ZR,
    output logic          ZV,
    output logic          SL0,
    output logic          SL1,
    output logic [2:0]    GNT,
    output logic [CW-1:0] BCNT
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
    localparam logic [CW-1:0] BCNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_r, state_s;
    logic [1:0]    lastg_r, lastg_s;
    logic [1:0]    gidx_r,  gidx_s;
    logic [2:0]    gnt_r,   gnt_s;
    logic [1:0]    sl_r,    sl_s;
    logic [CW-1:0] bcnt_r,  bcnt_s;
    logic [1:0]    pick_last_s;
    logic [2:0]    pick_s;
    logic          beat_s;
    logic          release_s;

    // Round-robin scan starting after 'last'; result is {found, index}.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] o0, o1, o2;
        case (last)
            2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
            2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
            default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
        endcase
        if (req[o0]) begin
            rr_pick = {1'b1, o0};
        end else if (req[o1]) begin
            rr_pick = {1'b1, o1};
        end else if (req[o2]) begin
            rr_pick = {1'b1, o2};
        end else begin
            rr_pick = 3'b000;
        end
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] g);
        case (g)
            2'd0:    onehot3 = 3'b001;
            2'd1:    onehot3 = 3'b010;
            2'd2:    onehot3 = 3'b100;
            default: onehot3 = 3'b000;
        endcase
    endfunction

    // {SL1,SL0}; the 11 code is never produced so the mux never sees an unused input.
    function automatic logic [1:0] sl_enc(input logic [1:0] g);
        case (g)
            2'd0:    sl_enc = 2'b00;
            2'd1:    sl_enc = 2'b01;
            2'd2:    sl_enc = 2'b10;
            default: sl_enc = 2'b00;
        endcase
    endfunction

    // Next-state: arbitration, burst counting and same-cycle re-arbitration on release.
    always_comb begin
        state_s     = state_r;
        lastg_s     = lastg_r;
        gidx_s      = gidx_r;
        gnt_s       = gnt_r;
        sl_s        = sl_r;
        bcnt_s      = bcnt_r;
        beat_s      = (state_r == ST_BUSY) && (|(gnt_r & REQ)) && ZR;
        release_s   = (state_r == ST_BUSY) &&
                      ((~|(gnt_r & REQ)) || (beat_s && (bcnt_r == BURST_LAST)));
        pick_last_s = (state_r == ST_BUSY) ? gidx_r : lastg_r;
        pick_s      = rr_pick(REQ, pick_last_s);

        case (state_r)
            ST_IDLE: begin
                if (pick_s[2]) begin
                    state_s = ST_BUSY;
                    gidx_s  = pick_s[1:0];
                    gnt_s   = onehot3(pick_s[1:0]);
                    sl_s    = sl_enc(pick_s[1:0]);
                    bcnt_s  = {CW{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (release_s) begin
                    lastg_s = gidx_r;
                    bcnt_s  = {CW{1'b0}};
                    if (pick_s[2]) begin
                        state_s = ST_BUSY;
                        gidx_s  = pick_s[1:0];
                        gnt_s   = onehot3(pick_s[1:0]);
                        sl_s    = sl_enc(pick_s[1:0]);
                    end else begin
                        state_s = ST_IDLE;
                        gnt_s   = 3'b000;
                    end
                end else if (beat_s) begin
                    bcnt_s = bcnt_r + BCNT_ONE;
                end else begin
                    bcnt_s = bcnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = 3'b000;
                bcnt_s  = {CW{1'b0}};
            end
        endcase
    end

    // Grant state register; reset leaves source 0 with first priority.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            lastg_r <= 2'd2;
            gidx_r  <= 2'd0;
            gnt_r   <= 3'b000;
            sl_r    <= 2'b00;
            bcnt_r  <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            lastg_r <= lastg_s;
            gidx_r  <= gidx_s;
            gnt_r   <= gnt_s;
            sl_r    <= sl_s;
            bcnt_r  <= bcnt_s;
        end
    end

    assign ZV   = |(gnt_r & REQ);
    assign ACK  = gnt_r & {3{ZR}};
    assign GNT  = gnt_r;
    assign SL0  = sl_r[0];
    assign SL1  = sl_r[1];
    assign BCNT = bcnt_r;

endmodule

// File: tb/tb_mux3_rr_select.sv
// Bench for mux3_rr_select: directed vectors push expected beats into a
// scoreboard; a monitor thread pops and checks each accepted beat.
module tb_mux3_rr_select;

    localparam int CW = 4;

    logic          CK = 1'b0;
    logic          RST;
    logic [2:0]    REQ;
    logic [2:0]    ACK;
    logic          ZR;
    logic          ZV;
    logic          SL0;
    logic          SL1;
    logic [2:0]    GNT;
    logic [CW-1:0] BCNT;

    typedef struct packed {
        logic [1:0]    src;
        logic [CW-1:0] bcnt;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_fails  = 0;
    logic [1:0] order_tab [4] = '{2'd2, 2'd0, 2'd1, 2'd2};

    mux3_rr_select #(.MAX_BURST(4), .CW(CW)) dut (
        .CK(CK), .RST(RST), .REQ(REQ), .ACK(ACK), .ZR(ZR), .ZV(ZV),
        .SL0(SL0), .SL1(SL1), .GNT(GNT), .BCNT(BCNT)
    );

    always #5 CK = ~CK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] oh(input logic [1:0] g);
        case (g)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
    endfunction

    task automatic exp_beat(input logic [1:0] src, input logic [CW-1:0] bc);
        sb.push_back('{src: src, bcnt: bc});
    endtask

    task automatic set_in(input logic [2:0] r, input logic z);
        REQ = r;
        ZR  = z;
    endtask

    task automatic mid();
        @(negedge CK);
    endtask

    task automatic fin();
        @(posedge CK);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"}, GNT, 3'b000);
        chk({tag, "_sl"}, {SL1, SL0}, 2'b00);
        chk({tag, "_zv"}, ZV, 1'b0);
        chk({tag, "_ack"}, ACK, 3'b000);
        chk({tag, "_bcnt"}, BCNT, 4'd0);
    endtask

    // Per-cycle invariants plus in-order beat checking against the scoreboard.
    task automatic monitor_loop();
        beat_t e;
        forever begin
            @(negedge CK);
            chk("sl_never_11", SL1 & SL0, 1'b0);
            chk("gnt_onehot0", $onehot0(GNT), 1'b1);
            if (!RST && ZV && ZR) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {29'd0, GNT}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("beat_gnt", GNT, oh(e.src));
                    chk("beat_sl", {SL1, SL0}, e.src);
                    chk("beat_bcnt", BCNT, e.bcnt);
                    chk("beat_ack", ACK, oh(e.src));
                end
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        REQ = 3'b000;
        ZR  = 1'b0;
        fork
            monitor_loop();
        join_none
        fin();
        fin();
        RST = 1'b0;
        mid();
        chk_reset_vals("reset");
        fin();

        // Single source: one-cycle latency, then bursts of 4 re-granted to itself.
        set_in(3'b010, 1'b1);
        mid();
        chk("lat_zv", ZV, 1'b0);
        chk("lat_gnt", GNT, 3'b000);
        fin();
        for (int i = 0; i < 6; i++) begin
            exp_beat(2'd1, CW'(i % 4));
            set_in(3'b010, 1'b1);
            if (i == 0) begin
                mid();
                chk("single_sl", {SL1, SL0}, 2'b01);
                chk("single_ack", ACK, 3'b010);
            end
            fin();
        end
        set_in(3'b000, 1'b1);
        mid();
        chk("drop_zv", ZV, 1'b0);
        chk("drop_ack", ACK, 3'b010);
        fin();
        set_in(3'b000, 1'b1);
        mid();
        chk("idle_gnt", GNT, 3'b000);
        chk("idle_sl_hold", {SL1, SL0}, 2'b01);
        chk("idle_bcnt", BCNT, 4'd0);
        chk("idle_zv", ZV, 1'b0);
        fin();

        // Three-way contention from last grant 1: order 2,0,1,2 without bubbles.
        set_in(3'b111, 1'b1);
        mid();
        chk("cont_idle_gnt", GNT, 3'b000);
        fin();
        for (int i = 0; i < 13; i++) begin
            exp_beat(order_tab[i / 4], CW'(i % 4));
            set_in(3'b111, 1'b1);
            fin();
        end

        // Early drop of source 2 at BCNT=1 re-arbitrates to source 0 in the same cycle.
        set_in(3'b001, 1'b1);
        mid();
        chk("early_zv", ZV, 1'b0);
        fin();
        exp_beat(2'd0, 4'd0);
        set_in(3'b001, 1'b1);
        mid();
        chk("early_gnt", GNT, 3'b001);
        chk("early_sl", {SL1, SL0}, 2'b00);
        chk("early_bcnt", BCNT, 4'd0);
        fin();

        // Backpressure at BCNT=1 holds everything.
        for (int i = 0; i < 5; i++) begin
            set_in(3'b001, 1'b0);
            mid();
            chk("stall_ack", ACK, 3'b000);
            chk("stall_zv", ZV, 1'b1);
            chk("stall_bcnt", BCNT, 4'd1);
            chk("stall_sl", {SL1, SL0}, 2'b00);
            fin();
        end
        exp_beat(2'd0, 4'd1);
        set_in(3'b001, 1'b1);
        fin();
        exp_beat(2'd0, 4'd2);
        set_in(3'b001, 1'b1);
        fin();
        exp_beat(2'd0, 4'd3);
        set_in(3'b011, 1'b1);
        fin();
        exp_beat(2'd1, 4'd0);
        set_in(3'b011, 1'b1);
        mid();
        chk("rotate_gnt", GNT, 3'b010);
        fin();

        // Reset mid-burst: no beat completes, outputs return to reset values.
        set_in(3'b111, 1'b1);
        RST = 1'b1;
        fin();
        RST = 1'b0;
        set_in(3'b111, 1'b1);
        mid();
        chk_reset_vals("midrst");
        fin();
        exp_beat(2'd0, 4'd0);
        set_in(3'b111, 1'b1);
        fin();
        exp_beat(2'd0, 4'd1);
        set_in(3'b111, 1'b1);
        fin();
        set_in(3'b000, 1'b0);
        fin();
        fin();

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
